// File: rtl/mixer_mc.sv
// Multi-channel audio mixer: slot-multiplexed accumulator, master attenuation,
// saturation with sticky clip flags, and first-order sigma-delta 1-bit DACs.
`timescale 1ns/1ps
module mixer_mc #(
    parameter int CHANNELS   = 4,
    parameter int WIDTH      = 8,
    parameter int BEEPER_W   = 64,
    parameter int TAPE_OUT_W = 16,
    parameter int TAPE_IN_W  = 8
) (
    input  logic                      clk28,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [CHANNELS*WIDTH-1:0] ch_data,
    input  logic [CHANNELS*2-1:0]     ch_pan,
    input  logic                      beeper,
    input  logic                      tape_out,
    input  logic                      tape_in,
    input  logic [1:0]                master_shift,
    input  logic                      clip_clr,
    output logic [WIDTH-1:0]          sample_l,
    output logic [WIDTH-1:0]          sample_r,
    output logic                      sample_valid,
    output logic                      clip_l,
    output logic                      clip_r,
    output logic                      dac_l,
    output logic                      dac_r
);

    localparam int ACC_W  = WIDTH + $clog2(CHANNELS + 3);
    localparam int SLOT_W = $clog2(CHANNELS + 2);
    localparam logic [SLOT_W-1:0] BIT_SLOT  = SLOT_W'(CHANNELS);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(CHANNELS + 1);

    logic [SLOT_W-1:0] slot;
    logic [ACC_W-1:0]  acc_l, acc_r;
    logic [WIDTH-1:0]  sd_l, sd_r;

    logic [WIDTH-1:0]  ch_word;
    logic [1:0]        pan_word;
    logic [ACC_W-1:0]  bit_sum, add_l, add_r;
    logic [ACC_W-1:0]  shr_l, shr_r;
    logic              over_l, over_r;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        ch_word  = '0;
        pan_word = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (slot == SLOT_W'(k)) begin
                ch_word  = ch_data[k*WIDTH +: WIDTH];
                pan_word = ch_pan[k*2 +: 2];
            end
        end
    end

    always_comb begin
        bit_sum = (beeper   ? ACC_W'(BEEPER_W)   : '0)
                + (tape_out ? ACC_W'(TAPE_OUT_W) : '0)
                + (tape_in  ? ACC_W'(TAPE_IN_W)  : '0);
        add_l = '0;
        add_r = '0;
        if (slot < BIT_SLOT) begin
            if (pan_word[0]) add_l = ACC_W'(ch_word);
            if (pan_word[1]) add_r = ACC_W'(ch_word);
        end else if (slot == BIT_SLOT) begin
            add_l = bit_sum;
            add_r = bit_sum;
        end
    end

    always_comb begin
        shr_l  = acc_l >> master_shift;
        shr_r  = acc_r >> master_shift;
        over_l = |shr_l[ACC_W-1:WIDTH];
        over_r = |shr_r[ACC_W-1:WIDTH];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of the others.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            slot         <= '0;
            acc_l        <= '0;
            acc_r        <= '0;
            sample_l     <= '0;
            sample_r     <= '0;
            sample_valid <= 1'b0;
            clip_l       <= 1'b0;
            clip_r       <= 1'b0;
            sd_l         <= '0;
            sd_r         <= '0;
            dac_l        <= 1'b0;
            dac_r        <= 1'b0;
        end else begin
            // A clip set later in this block overrides the clear on the same edge.
            if (clip_clr) begin
                clip_l <= 1'b0;
                clip_r <= 1'b0;
            end
            if (!en) begin
                slot         <= '0;
                acc_l        <= '0;
                acc_r        <= '0;
                sample_l     <= '0;
                sample_r     <= '0;
                sample_valid <= 1'b0;
                sd_l         <= '0;
                sd_r         <= '0;
                dac_l        <= 1'b0;
                dac_r        <= 1'b0;
            end else begin
                {dac_l, sd_l} <= {1'b0, sd_l} + {1'b0, sample_l};
                {dac_r, sd_r} <= {1'b0, sd_r} + {1'b0, sample_r};
                sample_valid  <= 1'b0;
                if (slot == LAST_SLOT) begin
                    slot         <= '0;
                    acc_l        <= '0;
                    acc_r        <= '0;
                    sample_valid <= 1'b1;
                    sample_l     <= over_l ? '1 : shr_l[WIDTH-1:0];
                    sample_r     <= over_r ? '1 : shr_r[WIDTH-1:0];
                    if (over_l) clip_l <= 1'b1;
                    if (over_r) clip_r <= 1'b1;
                end else begin
                    slot  <= slot + SLOT_W'(1);
                    acc_l <= acc_l + add_l;
                    acc_r <= acc_r + add_r;
                end
            end
        end
    end

endmodule

// File: tb/tb_mixer_mc.sv
// Directed bench for mixer_mc with a frame scoreboard of expected samples.
`timescale 1ns/1ps
module tb_mixer_mc;

    localparam int CH = 4;

    typedef struct packed {
        logic [7:0] l;
        logic [7:0] r;
        logic       cl;
        logic       cr;
    } exp_t;

    logic            clk28 = 1'b0;
    logic            rst_n;
    logic            en;
    logic [CH*8-1:0] ch_data;
    logic [CH*2-1:0] ch_pan;
    logic            beeper, tape_out, tape_in;
    logic [1:0]      master_shift;
    logic            clip_clr;
    logic [7:0]      sample_l, sample_r;
    logic            sample_valid, clip_l, clip_r, dac_l, dac_r;

    logic [7:0] data [CH];
    logic [1:0] pan  [CH];
    exp_t       sb [$];
    bit         exp_clip_l, exp_clip_r;
    int         checks = 0;
    int         errors = 0;
    int         cyc;

    always #5 clk28 = ~clk28;

    always_comb begin
        ch_data = '0;
        ch_pan  = '0;
        for (int k = 0; k < CH; k++) begin
            ch_data[k*8 +: 8] = data[k];
            ch_pan[k*2 +: 2]  = pan[k];
        end
    end

    mixer_mc dut (
        .clk28(clk28), .rst_n(rst_n), .en(en), .ch_data(ch_data), .ch_pan(ch_pan),
        .beeper(beeper), .tape_out(tape_out), .tape_in(tape_in),
        .master_shift(master_shift), .clip_clr(clip_clr),
        .sample_l(sample_l), .sample_r(sample_r), .sample_valid(sample_valid),
        .clip_l(clip_l), .clip_r(clip_r), .dac_l(dac_l), .dac_r(dac_r)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected result of one frame under the stimulus currently applied.
    function automatic exp_t model();
        int   sl, sr, bits;
        exp_t e;
        sl = 0;
        sr = 0;
        for (int k = 0; k < CH; k++) begin
            if (pan[k][0]) sl += int'(data[k]);
            if (pan[k][1]) sr += int'(data[k]);
        end
        bits = (beeper ? 64 : 0) + (tape_out ? 16 : 0) + (tape_in ? 8 : 0);
        sl = (sl + bits) >> master_shift;
        sr = (sr + bits) >> master_shift;
        if (sl > 255) begin e.l = 8'hFF; exp_clip_l = 1'b1; end else e.l = 8'(sl);
        if (sr > 255) begin e.r = 8'hFF; exp_clip_r = 1'b1; end else e.r = 8'(sr);
        e.cl = exp_clip_l;
        e.cr = exp_clip_r;
        return e;
    endfunction

    task automatic push_frame();
        sb.push_back(model());
    endtask

    task automatic wait_valid(input string tag, output int cycles);
        exp_t e;
        bit   seen;
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < 20) begin
            @(negedge clk28);
            cycles++;
            if (sample_valid === 1'b1) seen = 1'b1;
        end
        check({tag, "_valid_seen"}, 32'(seen), 32'd1);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        check({tag, "_sample_l"}, 32'(sample_l), 32'(e.l));
        check({tag, "_sample_r"}, 32'(sample_r), 32'(e.r));
        check({tag, "_clip_l"},   32'(clip_l),   32'(e.cl));
        check({tag, "_clip_r"},   32'(clip_r),   32'(e.cr));
    endtask

    task automatic sync_frame(input string tag);
        bit seen;
        int n;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 20) begin
            @(negedge clk28);
            n++;
            if (sample_valid === 1'b1) seen = 1'b1;
        end
        check({tag, "_sync"}, 32'(seen), 32'd1);
    endtask

    task automatic set_all(input logic [7:0] d, input logic [1:0] p);
        for (int k = 0; k < CH; k++) begin
            data[k] = d;
            pan[k]  = p;
        end
    endtask

    initial begin
        int ones_l, ones_r, vcount;
        rst_n = 1'b0; en = 1'b0; clip_clr = 1'b0; master_shift = 2'd0;
        beeper = 1'b0; tape_out = 1'b0; tape_in = 1'b0;
        set_all(8'h00, 2'b00);
        exp_clip_l = 1'b0; exp_clip_r = 1'b0;

        // Reset state
        @(negedge clk28);
        check("rst_sample_l", 32'(sample_l), 32'd0);
        check("rst_sample_r", 32'(sample_r), 32'd0);
        check("rst_valid",    32'(sample_valid), 32'd0);
        check("rst_clip",     32'({clip_l, clip_r}), 32'd0);
        check("rst_dac",      32'({dac_l, dac_r}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk28);

        // Single centred channel to both sides
        data[0] = 8'h80; pan[0] = 2'b11;
        en = 1'b1;
        push_frame();
        wait_valid("t1a", cyc);
        check("t1_first_latency", 32'(cyc), 32'd6);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk28);
            if (i == 0) check("t1_valid_one_cycle", 32'(sample_valid), 32'd0);
            check($sformatf("t1_dac_l_%0d", i), 32'(dac_l), 32'(i % 2));
            check($sformatf("t1_dac_r_%0d", i), 32'(dac_r), 32'(i % 2));
        end
        push_frame();
        wait_valid("t1b", cyc);
        check("t1_frame_period", 32'(cyc), 32'd2);

        // Left-only full scale saturates, then attenuation plus clip_clr
        set_all(8'hFF, 2'b01);
        push_frame();
        wait_valid("t2a", cyc);
        master_shift = 2'd2;
        clip_clr = 1'b1;
        exp_clip_l = 1'b0; exp_clip_r = 1'b0;
        push_frame();
        @(negedge clk28);
        clip_clr = 1'b0;
        check("t2_clip_cleared", 32'(clip_l), 32'd0);
        wait_valid("t2b", cyc);

        // One-bit sources only, then sigma-delta duty
        set_all(8'h00, 2'b11);
        master_shift = 2'd0;
        beeper = 1'b1; tape_out = 1'b1; tape_in = 1'b1;
        push_frame();
        wait_valid("t3", cyc);
        ones_l = 0; ones_r = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk28);
            ones_l += int'(dac_l);
            ones_r += int'(dac_r);
        end
        check("t3_duty_l", 32'(ones_l), 32'd88);
        check("t3_duty_r", 32'(ones_r), 32'd88);
        sync_frame("t3");

        // Channel 1 changed after its slot: effect deferred to next frame
        beeper = 1'b0; tape_out = 1'b0; tape_in = 1'b0;
        set_all(8'h00, 2'b00);
        data[1] = 8'h10; pan[1] = 2'b10;
        push_frame();
        @(negedge clk28);
        @(negedge clk28);
        data[1] = 8'h40;
        push_frame();
        wait_valid("t4a", cyc);
        wait_valid("t4b", cyc);

        // en dropped at slot 3: partial frame discarded
        repeat (3) @(negedge clk28);
        en = 1'b0;
        @(negedge clk28);
        check("t5_sample_l_off", 32'(sample_l), 32'd0);
        check("t5_sample_r_off", 32'(sample_r), 32'd0);
        check("t5_dac_off",      32'({dac_l, dac_r}), 32'd0);
        vcount = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk28);
            vcount += int'(sample_valid);
        end
        check("t5_no_valid_while_off", 32'(vcount), 32'd0);
        en = 1'b1;
        push_frame();
        wait_valid("t5", cyc);
        check("t5_restart_latency", 32'(cyc), 32'd6);

        // Clip hold through en=0, then async reset mid-frame
        set_all(8'hFF, 2'b01);
        push_frame();
        wait_valid("t6a", cyc);
        en = 1'b0;
        @(negedge clk28);
        check("t6_clip_hold_en0", 32'(clip_l), 32'd1);
        en = 1'b1;
        @(negedge clk28);
        @(negedge clk28);
        rst_n = 1'b0;
        #1;
        check("t6_rst_samples", 32'({sample_l, sample_r}), 32'd0);
        check("t6_rst_valid",   32'(sample_valid), 32'd0);
        check("t6_rst_clip",    32'({clip_l, clip_r}), 32'd0);
        check("t6_rst_dac",     32'({dac_l, dac_r}), 32'd0);
        exp_clip_l = 1'b0; exp_clip_r = 1'b0;
        master_shift = 2'd2;
        @(negedge clk28);
        rst_n = 1'b1;
        push_frame();
        wait_valid("t6b", cyc);
        check("t6_resume_latency", 32'(cyc), 32'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
